fir_capture_buffer: RTL and testbench

Sink at the output end of the filter chain. Consumes the valid-only sample stream (data/valid, no backpressure) produced by the FIR filter and captures a programmed number of samples into on-chip RAM, with optional decimation and trigger. A processor-side read port then reads the captured block.

---
 rtl/fir_capture_pkg.sv | 24 ++
 rtl/fir_capture_buffer_sdp_ram.sv | 37 +++
 rtl/fir_capture_buffer.sv | 122 ++++++++++++
 tb/tb_fir_capture_buffer.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_capture_pkg.sv
// Shared types and helpers for the FIR capture buffer: FSM encoding and
// sanitising of the capture length and decimation settings latched on arm.
package fir_capture_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } cap_state_e;

  localparam int DECIM_W = 16;

  // A length of zero, or one that would overrun the RAM, means "fill the RAM".
  function automatic int unsigned clamp_n_samples(input int unsigned n,
                                                  input int unsigned depth);
    return ((n == 0) || (n > depth)) ? depth : n;
  endfunction

  function automatic logic [DECIM_W-1:0] sanitize_decim(input logic [DECIM_W-1:0] d);
    return (d == '0) ? DECIM_W'(1) : d;
  endfunction

endpackage

// File: rtl/fir_capture_buffer_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read-first read port.
// The read register holds its value when no read is requested.
module sdp_ram #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Separate from the array write so the array itself stays reset-free.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_data_q <= '0;
    end else if (rd_en) begin
      rd_data_q <= mem[rd_addr];
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/fir_capture_buffer.sv
// Capture sink for the FIR output stream: on arm, stores n_samples decimated
// samples (optionally after a trigger) into RAM for later processor readout.
module fir_capture_buffer
  import fir_capture_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 1024
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                enable,
  input  logic                arm,
  input  logic                trig_mode,
  input  logic                trig,
  input  logic [ADDR_W:0]     n_samples,
  input  logic [DECIM_W-1:0]  decim,
  input  logic [DATA_W-1:0]   data_in,
  input  logic                data_in_valid,
  input  logic                rd_en,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic [DATA_W-1:0]   rd_data,
  output logic                rd_data_valid,
  output logic                busy,
  output logic                done,
  output logic [ADDR_W:0]     sample_count
);

  cap_state_e         state_q, state_d;
  logic [ADDR_W:0]    n_lat_q, n_lat_d;
  logic [DECIM_W-1:0] decim_lat_q, decim_lat_d;
  logic [DECIM_W-1:0] dec_cnt_q, dec_cnt_d;
  logic [ADDR_W:0]    count_q, count_d;
  logic [ADDR_W:0]    count_inc;
  logic               rd_valid_q;
  logic               wr_en;

  assign count_inc = count_q + 1'b1;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      n_lat_q     <= '0;
      decim_lat_q <= DECIM_W'(1);
      dec_cnt_q   <= '0;
      count_q     <= '0;
      rd_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      n_lat_q     <= n_lat_d;
      decim_lat_q <= decim_lat_d;
      dec_cnt_q   <= dec_cnt_d;
      count_q     <= count_d;
      rd_valid_q  <= rd_en;
    end
  end

  always_comb begin
    state_d     = state_q;
    n_lat_d     = n_lat_q;
    decim_lat_d = decim_lat_q;
    dec_cnt_d   = dec_cnt_q;
    count_d     = count_q;
    wr_en       = 1'b0;
    if (enable) begin
      if (arm) begin
        // Arm aborts whatever is in flight, even a sample arriving this cycle.
        n_lat_d     = (ADDR_W+1)'(clamp_n_samples(int'(n_samples), int'(DEPTH)));
        decim_lat_d = sanitize_decim(decim);
        dec_cnt_d   = '0;
        count_d     = '0;
        state_d     = trig_mode ? ST_ARMED : ST_CAPTURE;
      end else begin
        case (state_q)
          ST_ARMED: begin
            if (trig) begin
              state_d = ST_CAPTURE;
            end
          end
          ST_CAPTURE: begin
            if (data_in_valid) begin
              if (dec_cnt_q == '0) begin
                wr_en   = 1'b1;
                count_d = count_inc;
                if (count_inc == n_lat_q) begin
                  state_d = ST_DONE;
                end
              end
              dec_cnt_d = (dec_cnt_q == decim_lat_q - 1'b1) ? '0 : dec_cnt_q + 1'b1;
            end
          end
          ST_IDLE, ST_DONE: begin
            state_d = state_q;
          end
          default: begin
            state_d = ST_IDLE;
          end
        endcase
      end
    end
  end

  sdp_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (wr_en),
    .wr_addr (count_q[ADDR_W-1:0]),
    .wr_data (data_in),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  assign rd_data_valid = rd_valid_q;
  assign busy          = (state_q == ST_ARMED) || (state_q == ST_CAPTURE);
  assign done          = (state_q == ST_DONE);
  assign sample_count  = count_q;

endmodule

// File: tb/tb_fir_capture_buffer.sv
// Scoreboard bench for fir_capture_buffer: a behavioural capture model predicts
// RAM contents and status; reads are checked by a separate monitor.
module tb_fir_capture_buffer;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 16;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              enable;
  logic              arm;
  logic              trig_mode;
  logic              trig;
  logic [ADDR_W:0]   n_samples;
  logic [15:0]       decim;
  logic [DATA_W-1:0] data_in;
  logic              data_in_valid;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              rd_data_valid;
  logic              busy;
  logic              done;
  logic [ADDR_W:0]   sample_count;

  fir_capture_buffer #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .enable        (enable),
    .arm           (arm),
    .trig_mode     (trig_mode),
    .trig          (trig),
    .n_samples     (n_samples),
    .decim         (decim),
    .data_in       (data_in),
    .data_in_valid (data_in_valid),
    .rd_en         (rd_en),
    .rd_addr       (rd_addr),
    .rd_data       (rd_data),
    .rd_data_valid (rd_data_valid),
    .busy          (busy),
    .done          (done),
    .sample_count  (sample_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural model: phase 0 idle, 1 waiting for trigger, 2 capturing, 3 done.
  int          m_phase = 0;
  int          m_count = 0;
  int          m_n     = DEPTH;
  int          m_d     = 1;
  int          m_seen  = 0;
  logic [31:0] m_mem   [DEPTH];
  bit          m_known [DEPTH];

  typedef struct {
    logic [31:0] data;
    bit          chk;
    int          cyc;
  } rd_exp_t;
  rd_exp_t exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_status(input string tag);
    check({tag, "_busy"}, 64'(busy), 64'((m_phase == 1) || (m_phase == 2)));
    check({tag, "_done"}, 64'(done), 64'(m_phase == 3));
    check({tag, "_count"}, 64'(sample_count), 64'(m_count));
  endtask

  // One clock cycle: drive inputs, advance the model with what the DUT sees
  // at the coming edge, then check status just after the edge.
  task automatic step(input bit a, input bit tg, input bit v, input logic [31:0] dat,
                      input bit re = 1'b0, input int ra = 0);
    rd_exp_t e;
    arm           = a;
    trig          = tg;
    data_in_valid = v;
    data_in       = dat;
    rd_en         = re;
    rd_addr       = ADDR_W'(ra);
    if (re) begin
      e.data = m_mem[ra];
      e.chk  = m_known[ra];
      e.cyc  = cyc;
      exp_q.push_back(e);
    end
    if (enable) begin
      if (a) begin
        m_n     = ((n_samples == 0) || (int'(n_samples) > DEPTH)) ? DEPTH : int'(n_samples);
        m_d     = (decim == 0) ? 1 : int'(decim);
        m_count = 0;
        m_seen  = 0;
        m_phase = trig_mode ? 1 : 2;
      end else if (m_phase == 1) begin
        if (tg) m_phase = 2;
      end else if (m_phase == 2 && v) begin
        if (m_seen % m_d == 0) begin
          m_mem[m_count]   = dat;
          m_known[m_count] = 1'b1;
          m_count++;
          if (m_count == m_n) m_phase = 3;
        end
        m_seen++;
      end
    end
    @(posedge clk);
    #1;
    check_status("step");
    arm = 1'b0; trig = 1'b0; data_in_valid = 1'b0; rd_en = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    arm = 1'b0; trig = 1'b0; data_in_valid = 1'b0; rd_en = 1'b0;
    m_phase = 0;
    m_count = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    check_status("reset");
    check("reset_rd_data", 64'(rd_data), 64'h0);
    check("reset_rd_valid", 64'(rd_data_valid), 64'h0);
  endtask

  task automatic read_range(input int lo, input int hi);
    for (int a = lo; a <= hi; a++) step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, a);
    step(1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic configure(input bit tm, input int ns, input int dc);
    trig_mode = tm;
    n_samples = (ADDR_W+1)'(ns);
    decim     = 16'(dc);
  endtask

  // Read monitor: pops the scoreboard whenever the DUT presents read data.
  always @(negedge clk) begin
    if (reset_n && rd_data_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL rd_unexpected: rd_data_valid=1 with no read pending (cycle %0d)", cyc);
      end else begin
        rd_exp_t e;
        e = exp_q.pop_front();
        check("rd_latency", 64'(cyc), 64'(e.cyc + 1));
        if (e.chk) check("rd_data", 64'(rd_data), 64'(e.data));
      end
    end
  end

  initial begin
    enable = 1'b1;
    configure(1'b0, 8, 1);
    data_in = '0;
    rd_addr = '0;
    do_reset();

    // Immediate capture of 8 out of 10 samples.
    configure(1'b0, 8, 1);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b1, 32'(100 + i));
    check("imm_count", 64'(sample_count), 64'd8);
    read_range(0, 7);

    // Decimation by 3, valid every other cycle.
    configure(1'b0, 4, 3);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i <= 20; i++) begin
      step(1'b0, 1'b0, 1'b1, 32'(i));
      step(1'b0, 1'b0, 1'b0, 32'h0);
    end
    check("dec_done", 64'(done), 64'd1);
    read_range(0, 3);

    // Triggered capture; the sample in the trig cycle is dropped.
    configure(1'b1, 4, 1);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    for (int i = 1; i <= 5; i++) step(1'b0, 1'b0, 1'b1, 32'(i));
    step(1'b0, 1'b1, 1'b1, 32'd6);
    for (int i = 7; i <= 12; i++) step(1'b0, 1'b0, 1'b1, 32'(i));
    read_range(0, 3);

    // Re-arm mid-capture with a coincident sample; read-first probe at addr 5.
    configure(1'b0, 16, 1);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    for (int i = 1; i <= 5; i++) step(1'b0, 1'b0, 1'b1, 32'(i));
    step(1'b1, 1'b0, 1'b1, 32'd99);
    check("rearm_count", 64'(sample_count), 64'd0);
    for (int i = 0; i < 16; i++) step(1'b0, 1'b0, 1'b1, 32'(200 + i), (i == 5), 5);
    read_range(0, 15);

    // Length 0 clamps to the full depth.
    configure(1'b0, 0, 1);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b1, 32'(32'h1000 + i));
    check("clamp_count", 64'(sample_count), 64'd16);
    read_range(0, 15);

    // Enable low freezes everything except the read port.
    configure(1'b0, 8, 1);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b1, 32'h2000);
    step(1'b0, 1'b0, 1'b1, 32'h2001);
    enable = 1'b0;
    step(1'b0, 1'b0, 1'b1, 32'h2002, 1'b1, 0);
    step(1'b1, 1'b1, 1'b1, 32'h2003);
    step(1'b0, 1'b0, 1'b1, 32'h2004, 1'b1, 2);
    check("en_count", 64'(sample_count), 64'd2);
    enable = 1'b1;
    for (int i = 5; i < 8; i++) step(1'b0, 1'b0, 1'b1, 32'(32'h2000 + i));
    read_range(0, 4);

    // Reset in the middle of a capture.
    configure(1'b0, 8, 1);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 32'(32'h3000 + i));
    do_reset();

    // Randomised traffic with random re-arms, settings and reads.
    for (int k = 0; k < 600; k++) begin
      bit a, tg, v, re;
      int ra;
      enable    = ($urandom_range(0, 9) != 0);
      trig_mode = 1'($urandom_range(0, 1));
      n_samples = (ADDR_W+1)'($urandom_range(0, 20));
      decim     = 16'($urandom_range(0, 4));
      a  = ($urandom_range(0, 29) == 0);
      tg = ($urandom_range(0, 7) == 0);
      v  = ($urandom_range(0, 2) != 0);
      re = ($urandom_range(0, 2) == 0);
      ra = $urandom_range(0, DEPTH - 1);
      step(a, tg, v, $urandom, re, ra);
    end
    enable = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 32'h0);
    check("rd_outstanding", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
